// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver on the system clock: sync, glitch filter, frame check, E0/F0 folding, FWFT FIFO.
// A decoded code appears at the FIFO head one cycle after the stop-bit fall; a full FIFO drops the code and sets overflow.
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [7:0]                    code,
  output logic                          ext,
  output logic                          brk,
  output logic                          valid,
  input  logic                          ready,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_filt;
  logic                   r_clk_filt_d;
  logic [FW-1:0]          r_filt_cnt;

  state_t                 r_state;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_shift;
  logic                   r_par;
  logic [TW-1:0]          r_to_cnt;
  logic                   r_ext_pend;
  logic                   r_brk_pend;

  logic [9:0]             r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;

  logic w_clk_s, w_dat_s, w_fall;
  logic w_par_ok, w_good, w_is_e0, w_is_f0, w_push;
  logic w_empty, w_full, w_pop, w_wr, w_drop;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
  assign w_fall  = r_clk_filt_d & ~r_clk_filt;

  // Filtered clock only follows the synced line after FILTER_LEN consecutive differing cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_sync   <= '1;
      r_dat_sync   <= '1;
      r_clk_filt   <= 1'b1;
      r_clk_filt_d <= 1'b1;
      r_filt_cnt   <= '0;
    end else begin
      r_clk_sync   <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync   <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_filt_d <= r_clk_filt;
      if (w_clk_s == r_clk_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == FILT_LAST) begin
        r_clk_filt <= w_clk_s;
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + FW'(1);
      end
    end
  end

  assign w_par_ok = ^{r_shift, r_par};
  assign w_good   = w_fall && (r_state == S_STOP) && w_par_ok && w_dat_s;
  assign w_is_e0  = (r_shift == 8'hE0);
  assign w_is_f0  = (r_shift == 8'hF0);
  assign w_push   = w_good && !w_is_e0 && !w_is_f0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      r_to_cnt   <= '0;
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if ((r_state == S_IDLE) || w_fall) r_to_cnt <= '0;
      else                               r_to_cnt <= r_to_cnt + TW'(1);

      // A timed-out frame is abandoned but keeps any prefix already seen.
      if ((r_state != S_IDLE) && !w_fall && (r_to_cnt == TO_LAST)) begin
        r_state   <= S_IDLE;
        frame_err <= 1'b1;
      end else if (w_fall) begin
        case (r_state)
          S_IDLE: begin
            if (!w_dat_s) begin
              r_state   <= S_DATA;
              r_bit_cnt <= '0;
            end
          end
          S_DATA: begin
            r_shift   <= {w_dat_s, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= w_dat_s;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (!w_par_ok) begin
              parity_err <= 1'b1;
              r_ext_pend <= 1'b0;
              r_brk_pend <= 1'b0;
            end else if (!w_dat_s) begin
              frame_err  <= 1'b1;
              r_ext_pend <= 1'b0;
              r_brk_pend <= 1'b0;
            end else if (w_is_e0) begin
              r_ext_pend <= 1'b1;
            end else if (w_is_f0) begin
              r_brk_pend <= 1'b1;
            end else begin
              r_ext_pend <= 1'b0;
              r_brk_pend <= 1'b0;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);
  assign w_pop   = ready && !w_empty;
  // When full, a same-cycle pop frees the slot being written.
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= {r_ext_pend, r_brk_pend, r_shift};
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (ovf_clr)     overflow <= 1'b0;
      else if (w_drop) overflow <= 1'b1;
    end
  end

  assign {ext, brk, code} = r_mem[r_rd_ptr];
  assign valid            = !w_empty;
  assign count            = r_count;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed PS/2 frames plus random traffic against a queue-based reference model.
module tb_ps2_rx_fifo;
  localparam int SYNC  = 2;
  localparam int FILT  = 4;
  localparam int DEPTH = 8;
  localparam int TO    = 300;
  localparam int HALF  = 10;
  localparam int LAT   = SYNC + FILT + 1;

  logic clk = 1'b0;
  logic reset_n, ps2_clk, ps2_data, ready, ovf_clr;
  logic [7:0] code;
  logic ext, brk, valid, parity_err, frame_err, overflow;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  ps2_rx_fifo #(.SYNC_STAGES(SYNC), .FILTER_LEN(FILT), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .code(code), .ext(ext), .brk(brk), .valid(valid), .ready(ready), .count(count),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic [9:0] q[$];
  bit ext_p, brk_p, ovf_m;
  int exp_perr = 0, exp_ferr = 0;
  int n_perr = 0, n_ferr = 0, n_long = 0;
  logic perr_d = 1'b0, ferr_d = 1'b0;
  int lat;

  always @(posedge clk) begin
    perr_d <= parity_err;
    ferr_d <= frame_err;
    if (parity_err) n_perr <= n_perr + 1;
    if (frame_err)  n_ferr <= n_ferr + 1;
    if ((parity_err && perr_d) || (frame_err && ferr_d)) n_long <= n_long + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_frame(input logic [7:0] b, input bit bp, input bit bs);
    if (bp) begin
      exp_perr++; ext_p = 0; brk_p = 0;
    end else if (bs) begin
      exp_ferr++; ext_p = 0; brk_p = 0;
    end else if (b == 8'hE0) begin
      ext_p = 1;
    end else if (b == 8'hF0) begin
      brk_p = 1;
    end else begin
      if (q.size() < DEPTH) q.push_back({ext_p, brk_p, b});
      else ovf_m = 1;
      ext_p = 0; brk_p = 0;
    end
  endtask

  task automatic check_state();
    chk("count", 32'(count), q.size());
    chk("valid", 32'(valid), 32'(q.size() != 0));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    chk("parity_err_pulses", n_perr, exp_perr);
    chk("frame_err_pulses", n_ferr, exp_ferr);
    if (q.size() != 0) chk("head", 32'({ext, brk, code}), 32'(q[0]));
  endtask

  task automatic send_bit(input logic b, input bit meas);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= HALF; i++) begin
      @(negedge clk);
      if (meas && lat == 0 && valid) lat = i;
    end
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bp, input bit bs, input bit meas);
    logic par;
    par = ~^b;
    if (bp) par = ~par;
    lat = 0;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit(par, 1'b0);
    send_bit(~bs, meas);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
    model_frame(b, bp, bs);
    check_state();
  endtask

  task automatic drain();
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("pop_valid", 32'(valid), 32'(1));
      chk("pop_entry", 32'({ext, brk, code}), 32'(q[0]));
      ready = 1'b1;
      @(posedge clk);
      q.delete(0);
    end
    @(negedge clk);
    ready = 1'b0;
    chk("drained_count", 32'(count), 32'(0));
    chk("drained_valid", 32'(valid), 32'(0));
  endtask

  task automatic clear_ovf();
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    ovf_m = 0;
    chk("ovf_clr", 32'(overflow), 32'(0));
  endtask

  function automatic logic [7:0] rand_code();
    logic [7:0] b;
    b = 8'($urandom);
    while (b == 8'hE0 || b == 8'hF0) b = 8'($urandom);
    return b;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    int k;
    reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_code", 32'({ext, brk, code}), 32'(0));
    chk("rst_perr", 32'(parity_err), 32'(0));
    chk("rst_ferr", 32'(frame_err), 32'(0));
    chk("rst_ovf", 32'(overflow), 32'(0));
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single code: latency from stop-bit line drop to valid
    send_frame(8'h1C, 0, 0, 1);
    chk("latency", lat, LAT);
    drain();

    send_frame(8'hF0, 0, 0, 0); send_frame(8'h1C, 0, 0, 0); drain();
    send_frame(8'h1C, 0, 0, 0); drain();
    send_frame(8'hE0, 0, 0, 0); send_frame(8'hF0, 0, 0, 0); send_frame(8'h75, 0, 0, 0); drain();

    // Parity error discards the frame and the pending break
    send_frame(8'hF0, 0, 0, 0); send_frame(8'h1C, 1, 0, 0); send_frame(8'h1C, 0, 0, 0); drain();
    send_frame(8'h33, 1, 1, 0);
    send_frame(8'h12, 0, 1, 0);

    // Overflow
    for (int i = 0; i <= DEPTH; i++) send_frame(rand_code(), 0, 0, 0);
    clear_ovf();
    drain();

    // Timeout keeps the pending break; a 1-cycle glitch with data low is ignored
    send_frame(8'hF0, 0, 0, 0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 1'b0);
    ps2_data = 1'b1;
    repeat (TO + 50) @(negedge clk);
    exp_ferr++;
    check_state();
    ps2_data = 1'b0;
    @(negedge clk); ps2_clk = 1'b0;
    @(negedge clk); ps2_clk = 1'b1;
    repeat (3) @(negedge clk); ps2_data = 1'b1;
    repeat (20) @(negedge clk);
    check_state();
    send_frame(8'h29, 0, 0, 0); drain();

    // Clock pulse with data high in idle is not a start bit
    send_bit(1'b1, 1'b0);
    repeat (20) @(negedge clk);
    check_state();
    send_frame(8'h4D, 0, 0, 0); drain();

    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 9);
      rb = 8'($urandom);
      case (k)
        0:       send_frame(rb, 1, 1'($urandom_range(0, 1)), 0);
        1:       send_frame(rb, 0, 1, 0);
        2:       send_frame(8'hE0, 0, 0, 0);
        3:       send_frame(8'hF0, 0, 0, 0);
        default: send_frame(rb, 0, 0, 0);
      endcase
      if ($urandom_range(0, 4) == 0) drain();
      if ($urandom_range(0, 9) == 0) clear_ovf();
    end
    drain();

    // Reset mid-frame with FIFO contents
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'h6B, 0, 0, 0);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_count", 32'(count), 32'(0));
    chk("midrst_valid", 32'(valid), 32'(0));
    q.delete(); ext_p = 0; brk_p = 0; ovf_m = 0;
    ps2_clk = 1'b1; ps2_data = 1'b1;
    @(negedge clk); reset_n = 1'b1;
    repeat (5) @(negedge clk);
    send_frame(8'h5A, 0, 0, 0); drain();

    chk("pulse_width", n_long, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
